// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the 128 x 32 data memory.
// Port 0 (pipeline) wins by default; a starvation counter and a bounded
// lock mode make sure port 1 (DMA/debug loader) always makes progress.
module dmem_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_stall,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read_e,
  output logic              mem_write_e,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    SHARED   = 1'b0,
    P1_BURST = 1'b1
  } state_t;

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [3:0]        burst_inc;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              p0_rvalid_q, p0_rvalid_d;
  logic              p1_rvalid_q, p1_rvalid_d;
  logic              sel_p0, sel_p1, locked_win;

  // Winner selection: a live lock owns the memory, otherwise port 0 wins unless port 1 is starved.
  always_comb begin
    sel_p0     = 1'b0;
    sel_p1     = 1'b0;
    locked_win = (state_q == P1_BURST) && p1_req && p1_lock && (burst_cnt_q < MAX_BURST_C);
    if (rst_n) begin
      if (locked_win) begin
        sel_p1 = 1'b1;
      end else if (p0_req && p1_req) begin
        if (wait_cnt_q == MAX_WAIT_C) sel_p1 = 1'b1;
        else                          sel_p0 = 1'b1;
      end else if (p0_req) begin
        sel_p0 = 1'b1;
      end else if (p1_req) begin
        sel_p1 = 1'b1;
      end
    end
  end

  // Memory pin drive: mux the winner's request, everything idles at zero with no grant.
  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_read_e  = 1'b0;
    mem_write_e = 1'b0;
    if (sel_p0) begin
      mem_addr    = p0_addr;
      mem_wdata   = p0_wdata;
      mem_write_e = p0_we;
      mem_read_e  = ~p0_we;
    end else if (sel_p1) begin
      mem_addr    = p1_addr;
      mem_wdata   = p1_wdata;
      mem_write_e = p1_we;
      mem_read_e  = ~p1_we;
    end
  end

  // Next state: starvation counter, burst ownership and read-return capture.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    burst_inc   = burst_cnt_q + 4'd1;

    if (!p1_req || sel_p1)          wait_cnt_d = 4'd0;
    else if (wait_cnt_q < MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;

    case (state_q)
      SHARED: begin
        if (sel_p1 && p1_lock) begin
          if (MAX_BURST_C == 4'd1) begin
            state_d     = SHARED;
            burst_cnt_d = 4'd0;
          end else begin
            state_d     = P1_BURST;
            burst_cnt_d = 4'd1;
          end
        end
      end
      P1_BURST: begin
        if (locked_win && (burst_inc != MAX_BURST_C)) begin
          burst_cnt_d = burst_inc;
        end else begin
          state_d     = SHARED;
          burst_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d     = SHARED;
        burst_cnt_d = 4'd0;
      end
    endcase

    p0_rvalid_d = sel_p0 & ~p0_we;
    p1_rvalid_d = sel_p1 & ~p1_we;
    p0_rdata_d  = p0_rvalid_d ? mem_rdata : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? mem_rdata : p1_rdata_q;
  end

  // State and return registers; reset aborts any burst and drops pending read returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SHARED;
      wait_cnt_q  <= 4'd0;
      burst_cnt_q <= 4'd0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  assign p0_gnt    = sel_p0;
  assign p1_gnt    = sel_p1;
  assign p0_stall  = rst_n & p0_req & ~sel_p0;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;

endmodule
